// File: rtl/stopwatch_bcd_pkg.sv
// stopwatch_pkg: shared types and constants for the MM:SS BCD stopwatch.
//   sw_state_t   - controller state encoding (IDLE, RUN, PAUSE, SAT)
//   BCD_W        - width of one BCD digit
//   *_MAX        - wrap limit of each digit in the carry chain
//   SAT_DIGITS   - packed 99:59, the value at which counting saturates
//   digit_max()  - wrap limit by chain position (0 = sec ones .. 3 = min tens)
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_SAT   = 2'd3
    } sw_state_t;

    localparam int BCD_W = 4;

    localparam logic [BCD_W-1:0] SEC_ONES_MAX = 4'd9;
    localparam logic [BCD_W-1:0] SEC_TENS_MAX = 4'd5;
    localparam logic [BCD_W-1:0] MIN_ONES_MAX = 4'd9;
    localparam logic [BCD_W-1:0] MIN_TENS_MAX = 4'd9;

    localparam logic [4*BCD_W-1:0] SAT_DIGITS =
        {MIN_TENS_MAX, MIN_ONES_MAX, SEC_TENS_MAX, SEC_ONES_MAX};

    function automatic logic [BCD_W-1:0] digit_max(input int idx);
        case (idx)
            0:       return SEC_ONES_MAX;
            1:       return SEC_TENS_MAX;
            2:       return MIN_ONES_MAX;
            default: return MIN_TENS_MAX;
        endcase
    endfunction

endpackage

// File: rtl/stopwatch_bcd_digit.sv
// bcd_digit_up: one up-counting BCD digit of the stopwatch carry chain.
// Ports:
//   clk       - clock, rising edge
//   reset     - asynchronous active-low reset, digit -> 0
//   clear     - synchronous clear, digit -> 0
//   inc_in    - increment request from the previous stage (or the prescaler)
//   carry_out - combinational: inc_in while this digit sits at MAX
//   digit     - current BCD value, 0..MAX
module bcd_digit_up
    import stopwatch_pkg::*;
#(
    parameter logic [BCD_W-1:0] MAX = SEC_ONES_MAX
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             inc_in,
    output logic             carry_out,
    output logic [BCD_W-1:0] digit
);

    // Combinational carry lets the whole chain settle inside one cycle, so
    // every digit updates on the same edge and no partial value is visible.
    assign carry_out = inc_in && (digit == MAX);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            digit <= '0;
        end else if (clear) begin
            digit <= '0;
        end else if (inc_in) begin
            digit <= (digit == MAX) ? '0 : digit + BCD_W'(1);
        end
    end

endmodule

// File: rtl/stopwatch_bcd.sv
// stopwatch_bcd: four-digit MM:SS BCD up-counting stopwatch.
// Parameters:
//   TICK_DIV   - clk cycles per counted second (>= 2)
// Ports:
//   clk        - clock, rising edge
//   reset      - asynchronous active-low reset
//   start      - begin / resume counting (level)
//   stop       - pause counting (level, beats start)
//   clear      - synchronous clear to 00:00 and IDLE (beats everything)
//   lap        - capture current time into lap_digits
//   digits     - packed BCD {min tens, min ones, sec tens, sec ones}
//   lap_digits - captured time, same packing
//   tick       - one-cycle pulse aligned with each new digits value
//   running    - high in RUN
//   saturated  - high in SAT (held at 99:59)
// Optional feature macro: STOPWATCH_LAP_EN builds the lap capture register;
// without it lap is ignored and lap_digits is tied to zero.
module stopwatch_bcd
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        stop,
    input  logic        clear,
    input  logic        lap,
    output logic [15:0] digits,
    output logic [15:0] lap_digits,
    output logic        tick,
    output logic        running,
    output logic        saturated
);

    localparam int             PW       = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]  PRE_LAST = PW'(TICK_DIV - 1);

    sw_state_t     state_reg;
    logic [PW-1:0] pre_reg;
    logic          tick_reg;
    logic          running_reg;
    logic          sat_reg;

    logic          terminal;
    logic          all_max;
    logic          chain_inc;
    logic [4:0]    carry;
    logic          overflow_unused;

    // A stop or clear on the terminal cycle wins: the increment is withheld
    // and the prescaler keeps its terminal value for the next RUN cycle.
    assign terminal  = (state_reg == ST_RUN) && !clear && !stop && (pre_reg == PRE_LAST);
    assign all_max   = (digits == SAT_DIGITS);
    // Gate the chain at 99:59 so the min-tens digit can never wrap.
    assign chain_inc = terminal && !all_max;
    assign carry[0]  = chain_inc;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_digit
            bcd_digit_up #(
                .MAX(digit_max(gi))
            ) u_digit (
                .clk      (clk),
                .reset    (reset),
                .clear    (clear),
                .inc_in   (carry[gi]),
                .carry_out(carry[gi+1]),
                .digit    (digits[gi*BCD_W +: BCD_W])
            );
        end
    endgenerate

    // The chain input is blocked at 99:59, so the final carry is always low.
    assign overflow_unused = carry[4];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= ST_IDLE;
            pre_reg     <= '0;
            tick_reg    <= 1'b0;
            running_reg <= 1'b0;
            sat_reg     <= 1'b0;
        end else begin
            tick_reg <= chain_inc;
            if (clear) begin
                state_reg   <= ST_IDLE;
                pre_reg     <= '0;
                running_reg <= 1'b0;
                sat_reg     <= 1'b0;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        if (start && !stop) begin
                            state_reg   <= ST_RUN;
                            pre_reg     <= '0;
                            running_reg <= 1'b1;
                        end
                    end
                    ST_RUN: begin
                        if (stop) begin
                            state_reg   <= ST_PAUSE;
                            running_reg <= 1'b0;
                        end else if (pre_reg == PRE_LAST) begin
                            pre_reg <= '0;
                            if (all_max) begin
                                state_reg   <= ST_SAT;
                                running_reg <= 1'b0;
                                sat_reg     <= 1'b1;
                            end
                        end else begin
                            pre_reg <= pre_reg + PW'(1);
                        end
                    end
                    ST_PAUSE: begin
                        // Prescaler stays frozen; RUN resumes from its value.
                        if (start && !stop) begin
                            state_reg   <= ST_RUN;
                            running_reg <= 1'b1;
                        end
                    end
                    default: begin
                        // SAT: only clear (handled above) leaves this state.
                    end
                endcase
            end
        end
    end

    assign tick      = tick_reg;
    assign running   = running_reg;
    assign saturated = sat_reg;

`ifdef STOPWATCH_LAP_EN
    logic [15:0] lap_reg;

    // Captures the digits present before this edge, so a lap coinciding
    // with an increment records the pre-increment time.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lap_reg <= '0;
        end else if (clear) begin
            lap_reg <= '0;
        end else if (lap && (state_reg != ST_IDLE)) begin
            lap_reg <= digits;
        end
    end

    assign lap_digits = lap_reg;
`else
    logic lap_unused;
    assign lap_unused = lap;
    assign lap_digits = '0;
`endif

endmodule

// File: tb/tb_stopwatch_bcd.sv
// Testbench for stopwatch_bcd with TICK_DIV = 4. A seconds-based reference
// model feeds a per-cycle scoreboard; a vector table and hand-written
// sequences add fixed expected values for the corner cases.
module tb_stopwatch_bcd;

    localparam int TD = 4;
    localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_SAT = 3;

`ifdef STOPWATCH_LAP_EN
    localparam logic [15:0] LAP_A = 16'h0007;
    localparam logic [15:0] LAP_B = 16'h1002;
    localparam logic [15:0] LAP_C = 16'h9959;
`else
    localparam logic [15:0] LAP_A = 16'h0000;
    localparam logic [15:0] LAP_B = 16'h0000;
    localparam logic [15:0] LAP_C = 16'h0000;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        clear = 1'b0;
    logic        lap = 1'b0;
    logic [15:0] digits;
    logic [15:0] lap_digits;
    logic        tick;
    logic        running;
    logic        saturated;

    stopwatch_bcd #(.TICK_DIV(TD)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .stop      (stop),
        .clear     (clear),
        .lap       (lap),
        .digits    (digits),
        .lap_digits(lap_digits),
        .tick      (tick),
        .running   (running),
        .saturated (saturated)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state: elapsed whole seconds, prescaler, state, lap.
    int m_secs, m_pre, m_state, m_lap;
    bit m_tick;
    logic [34:0] exp_q[$];

    typedef struct {
        bit          s, p, c;
        int          n;
        logic [15:0] d;
        bit          t, r, sat;
    } vec_t;
    vec_t vecs[11];

    function automatic logic [15:0] to_bcd(input int s);
        int mm, ss;
        mm = s / 60;
        ss = s % 60;
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
    endfunction

    task automatic chk(input string name, input logic [39:0] act, input logic [39:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    task automatic model_reset();
        m_secs = 0; m_pre = 0; m_state = S_IDLE; m_lap = 0; m_tick = 0;
        exp_q.delete();
    endtask

    task automatic model_step(input bit s, input bit p, input bit c, input bit l);
        m_tick = 0;
        if (c) begin
            m_secs = 0; m_pre = 0; m_state = S_IDLE; m_lap = 0;
        end else begin
`ifdef STOPWATCH_LAP_EN
            if (l && m_state != S_IDLE) m_lap = m_secs;
`else
            if (l) m_lap = 0;
`endif
            case (m_state)
                S_IDLE:  if (s && !p) begin m_state = S_RUN; m_pre = 0; end
                S_RUN: begin
                    if (p) m_state = S_PAUSE;
                    else if (m_pre == TD - 1) begin
                        m_pre = 0;
                        if (m_secs == 99 * 60 + 59) m_state = S_SAT;
                        else begin m_secs++; m_tick = 1; end
                    end else m_pre++;
                end
                S_PAUSE: if (s && !p) m_state = S_RUN;
                default: ;
            endcase
        end
    endtask

    // One clock: drive inputs, queue the model's expectation, compare after the edge.
    task automatic cycle(input bit s, input bit p, input bit c, input bit l);
        start = s; stop = p; clear = c; lap = l;
        model_step(s, p, c, l);
        exp_q.push_back({to_bcd(m_secs), to_bcd(m_lap), m_tick,
                         m_state == S_RUN, m_state == S_SAT});
        @(posedge clk);
        #1;
        chk("cycle_outputs", {5'd0, digits, lap_digits, tick, running, saturated},
            {5'd0, exp_q.pop_front()});
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        //           s  p  c   n   digits    t  r  sat
        vecs[0]  = '{1, 0, 0,  1, 16'h0000, 0, 1, 0};  // start
        vecs[1]  = '{0, 0, 0,  3, 16'h0000, 0, 1, 0};  // prescaler 1..3
        vecs[2]  = '{0, 0, 0,  1, 16'h0001, 1, 1, 0};  // first increment
        vecs[3]  = '{0, 0, 0, 36, 16'h0010, 1, 1, 0};  // 40 cycles after start
        vecs[4]  = '{0, 1, 0,  1, 16'h0010, 0, 0, 0};  // pause
        vecs[5]  = '{1, 1, 0,  2, 16'h0010, 0, 0, 0};  // stop beats start
        vecs[6]  = '{1, 0, 0,  1, 16'h0010, 0, 1, 0};  // resume
        vecs[7]  = '{0, 0, 0,  4, 16'h0011, 1, 1, 0};  // next second
        vecs[8]  = '{0, 1, 1,  1, 16'h0000, 0, 0, 0};  // clear beats stop
        vecs[9]  = '{1, 1, 0,  1, 16'h0000, 0, 0, 0};  // start+stop in IDLE
        vecs[10] = '{0, 0, 1,  1, 16'h0000, 0, 0, 0};  // clear in IDLE

        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_digits", {24'd0, digits}, 40'h0);
        chk("reset_lap", {24'd0, lap_digits}, 40'h0);
        chk("reset_flags", {37'd0, tick, running, saturated}, 40'h0);
        reset = 1'b1;

        for (int i = 0; i < 11; i++) begin
            for (int k = 0; k < vecs[i].n; k++) cycle(vecs[i].s, vecs[i].p, vecs[i].c, 1'b0);
            chk($sformatf("vec%0d_digits", i), {24'd0, digits}, {24'd0, vecs[i].d});
            chk($sformatf("vec%0d_flags", i), {37'd0, tick, running, saturated},
                {37'd0, vecs[i].t, vecs[i].r, vecs[i].sat});
        end

        // Lap at 00:07, then carry 09:59 -> 10:00.
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 100 && m_secs < 7; k++) idle();
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        chk("lap_capture", {24'd0, lap_digits}, {24'd0, LAP_A});
        for (int k = 0; k < 5000 && m_secs < 599; k++) idle();
        chk("pre_carry", {24'd0, digits}, 40'h0959);
        chk("lap_held", {24'd0, lap_digits}, {24'd0, LAP_A});
        repeat (4) idle();
        chk("carry_chain", {24'd0, digits}, 40'h1000);
        chk("carry_tick", {39'd0, tick}, 40'h1);

        // Pause two cycles after a tick, hold 20 cycles, resume.
        idle();
        idle();
        repeat (20) cycle(1'b0, 1'b1, 1'b0, 1'b0);
        chk("pause_hold", {23'd0, digits, running}, {23'd0, 16'h1000, 1'b0});
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        idle();
        chk("resume_early", {23'd0, digits, tick}, {23'd0, 16'h1000, 1'b0});
        idle();
        chk("resume_tick", {23'd0, digits, tick}, {23'd0, 16'h1001, 1'b1});

        // Stop on the terminal prescaler cycle: increment waits for resume.
        repeat (3) idle();
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        chk("stop_at_terminal", {23'd0, digits, tick}, {23'd0, 16'h1001, 1'b0});
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        chk("resume_edge", {24'd0, digits}, 40'h1001);
        idle();
        chk("resume_first_run", {23'd0, digits, tick}, {23'd0, 16'h1002, 1'b1});

        // Lap coinciding with an increment captures the old value.
        repeat (3) idle();
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        chk("lap_coincident", {8'd0, digits, lap_digits}, {8'd0, 16'h1003, LAP_B});

        // Saturation at 99:59.
        for (int k = 0; k < 30000 && m_state != S_SAT; k++) idle();
        chk("sat_digits", {24'd0, digits}, 40'h9959);
        chk("sat_flags", {37'd0, tick, running, saturated}, 40'h1);
        repeat (8) idle();
        chk("sat_hold", {23'd0, digits, tick}, {23'd0, 16'h9959, 1'b0});
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        chk("sat_start_ignored", {21'd0, digits, tick, running, saturated},
            {21'd0, 16'h9959, 3'b001});
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        chk("sat_lap", {24'd0, lap_digits}, {24'd0, LAP_C});
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        chk("sat_clear", {5'd0, digits, lap_digits, tick, running, saturated}, 40'h0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        chk("idle_after_clear", {39'd0, running}, 40'h0);

        // Asynchronous reset between edges while tick is high.
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (4) idle();
        chk("pre_reset", {22'd0, digits, tick, running}, {22'd0, 16'h0001, 2'b11});
        #2 reset = 1'b0;
        #1;
        chk("async_reset", {5'd0, digits, lap_digits, tick, running, saturated}, 40'h0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        chk("run_after_reset", {23'd0, digits, running}, {23'd0, 16'h0000, 1'b1});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stopwatch_bcd.md
# stopwatch_bcd

Four-digit MM:SS BCD up-counting stopwatch that measures how long the player takes to answer a challenge. It is the count-up counterpart of the per-digit countdown timer chain: a prescaled one-second tick increments a ripple-carry digit chain instead of borrowing down it. It sits beside the countdown timer in the challenge datapath and feeds the same seven-segment display mux.

## Interface
- `TICK_DIV`, 50_000_000: clk cycles per counted second; must be ≥ 2.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low; 0 forces the reset state immediately.
- `start` in 1: level sampled each cycle; begins or resumes counting.
- `stop` in 1: level sampled each cycle; pauses counting.
- `clear` in 1: synchronous clear to 00:00 and IDLE.
- `lap` in 1: capture the current time into `lap_digits` (only with `STOPWATCH_LAP_EN`).
- `digits` out 16: packed BCD. [3:0] is sec ones (0–9), [7:4] is sec tens (0–5), [11:8] is min ones (0–9), [15:12] is min tens (0–9).
- `lap_digits` out 16: captured time, same packing.
- `tick` out 1: one-cycle pulse on the cycle the digits increment.
- `running` out 1: high in RUN.
- `saturated` out 1: high in SAT.

## Operation
- States: IDLE, RUN, PAUSE, SAT.
- Reset and `clear`:
  - Reset values: `digits`=0, `lap_digits`=0, `tick`=0, `running`=0, `saturated`=0, prescaler=0, state IDLE.
  - `clear` has the same effect synchronously, in any state.
- Input priority each cycle: `clear` > `stop` > `start`.
- Transitions:
  - IDLE with `start` goes to RUN; the prescaler is restarted at 0.
  - RUN with `stop` goes to PAUSE; the prescaler value is retained.
  - PAUSE with `start` goes to RUN; the prescaler resumes from its retained value.
  - RUN reaching 99:59 at a tick goes to SAT.
  - SAT exits only on `clear`; `start` and `stop` are ignored.
- Prescaler:
  - In RUN it counts 0..TICK_DIV-1.
  - At TICK_DIV-1 it wraps to 0 and issues an increment.
  - It is frozen outside RUN.
- Increment: sec ones +1, with a ripple carry on each digit's wrap:
  - sec ones 9 wraps to 0.
  - sec tens 5 wraps to 0.
  - min ones 9 wraps to 0.
  - min tens 9 sets saturation; it never wraps.
- Saturation:
  - The increment that would take 99:59 to 100:00 is suppressed; `digits` holds 99:59.
  - `saturated` is set and the state goes to SAT. No `tick` is issued for that increment.
- A `stop` in the same cycle as the prescaler terminal count wins. No increment happens and the prescaler is held at TICK_DIV-1; the increment fires on the first RUN cycle after resume.
- Digits are never loaded from outside. Illegal BCD codes cannot arise.

## Timing
- `start` is sampled at edge N. `running`=1 after edge N; the first increment lands at edge N+TICK_DIV.
- Increment and carry: all four digits update on the same edge the prescaler wraps. The carry ripple is combinational within that cycle.
- `tick` is registered and high for exactly the one cycle following the digit update edge, aligned with the new `digits` value.
- `stop` takes effect at the sampling edge. Digits never change after that edge.
- `clear` takes effect at the sampling edge. `digits`=0 is visible the following cycle.
- Reset asserted mid-count forces all outputs to their reset values immediately, without waiting for a clock edge. Deassertion should be synchronized upstream.

## Configuration
- `STOPWATCH_LAP_EN` defined:
  - On a `lap` pulse in RUN, PAUSE or SAT, `lap_digits` takes the current `digits` at the sampling edge.
  - If a `lap` pulse coincides with an increment, the pre-increment value is captured.
  - `clear` zeroes `lap_digits`.
- `STOPWATCH_LAP_EN` undefined: `lap` is ignored and `lap_digits` is constant 0. No capture register is built.

## Structure
- Package `stopwatch_pkg`:
  - State enum `sw_state_t`.
  - BCD width constant (4).
  - Digit limits `SEC_ONES_MAX`=9, `SEC_TENS_MAX`=5, `MIN_ONES_MAX`=9, `MIN_TENS_MAX`=9.
- Sub-module `bcd_digit_up`:
  - Parameter MAX; ports `inc_in`, `carry_out`, `digit`, plus clock, reset and clear.
  - Instantiated four times in the carry chain.
  - `carry_out` is combinational: `inc_in` && `digit`==MAX.
  - The top-level FSM owns the prescaler and saturation detection.

## Test plan
All scenarios use `TICK_DIV`=4.
- Basic count:
  - Stimulus: reset, then `start` one cycle.
  - Response: first `tick` 4 cycles later with `digits`=16'h0001; after 40 cycles `digits`=16'h0010.
- Carry chain:
  - Stimulus: run to 09:59 and count one more tick.
  - Response: `digits`=16'h1000 on a single edge; no intermediate value is visible.
- Pause and resume:
  - Stimulus: assert `stop` 2 cycles after a tick; hold 20 cycles; then `start`.
  - Response: `digits` unchanged during the hold; next tick 2 cycles after resume.
- Saturation:
  - Stimulus: count to 99:59, then run 8 more cycles; then assert `start`.
  - Response: `digits`=16'h9959, `saturated`=1, no further `tick`; `start` ignored.
  - Follow-up: `clear` gives IDLE and 16'h0000.
- Priority and reset:
  - Simultaneous `start`+`stop` in IDLE: stays IDLE.
  - `clear`+`stop` in RUN: IDLE with 0.
  - `reset` low mid-cycle: outputs zero before the next edge.
- Lap (macro defined):
  - Stimulus: `lap` at 00:07, then keep counting.
  - Response: `lap_digits`=16'h0007 held while `digits` advances.
  - Macro undefined: `lap_digits` stays 0.
